// File: rtl/tx_sched_pkg.sv
// Shared types and arithmetic helpers for the XGMII transmit scheduler.
// Length/gap rules are expressed in bytes and converted to 8-byte XGMII cycles.
package tx_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } tx_state_e;

   localparam int unsigned XGMII_BYTES    = 8;
   localparam int unsigned PREAMBLE_BYTES = 8;
   localparam logic [29:0] GAP_CYC_MAX    = 30'h2000_0000;

   function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] min_len);
      logic [15:0] res;
      if (len < min_len) begin
         res = min_len;
      end else begin
         res = len;
      end
      return res;
   endfunction

   // Frame occupancy in cycles, preamble/SFD included, rounded up.
   function automatic logic [13:0] frame_cycles(input logic [16:0] len);
      logic [16:0] sum;
      sum = len + 17'(PREAMBLE_BYTES) + 17'(XGMII_BYTES - 1);
      return sum[16:3];
   endfunction

   function automatic logic [29:0] gap_cycles(input logic [31:0] ifg, input logic [32:0] min_ifg);
      logic [32:0] gap_b;
      logic [32:0] sum;
      logic [29:0] cyc;
      gap_b = ({1'b0, ifg} < min_ifg) ? min_ifg : {1'b0, ifg};
      sum   = gap_b + 33'(XGMII_BYTES - 1);
      cyc   = sum[32:3];
      if (cyc > GAP_CYC_MAX) begin
         cyc = GAP_CYC_MAX;
      end else if (cyc == 30'd0) begin
         cyc = 30'd1;
      end else begin
         cyc = cyc;
      end
      return cyc;
   endfunction

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/tx_rate_stats.sv
// tx_rate_stats: one-second window of accepted frames and frame bits.
// A handshake in the wrap cycle is counted in the new window.
module tx_rate_stats
   import tx_sched_pkg::*;
#(
   parameter int unsigned CLK_HZ = 156_250_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        frame_acc,
   input  logic [18:0] frame_bits,
   output logic [31:0] tx_pps,
   output logic [31:0] tx_throughput
);

   localparam int unsigned     WIN_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ - 1);

   logic [WIN_W-1:0] win_r;
   logic [31:0]      frm_acc_r;
   logic [31:0]      bit_acc_r;
   logic [31:0]      pps_r;
   logic [31:0]      thr_r;
   logic             wrap_s;
   logic [31:0]      bits_s;

   assign wrap_s = (win_r == WIN_LAST);
   assign bits_s = {13'd0, frame_bits};

   // Window counter, saturating accumulators and the published snapshot.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         win_r     <= '0;
         frm_acc_r <= 32'd0;
         bit_acc_r <= 32'd0;
         pps_r     <= 32'd0;
         thr_r     <= 32'd0;
      end else if (wrap_s) begin
         win_r     <= '0;
         pps_r     <= frm_acc_r;
         thr_r     <= bit_acc_r;
         frm_acc_r <= frame_acc ? 32'd1 : 32'd0;
         bit_acc_r <= frame_acc ? bits_s : 32'd0;
      end else begin
         win_r <= win_r + WIN_W'(1);
         if (frame_acc) begin
            frm_acc_r <= sat_add32(frm_acc_r, 32'd1);
            bit_acc_r <= sat_add32(bit_acc_r, bits_s);
         end
      end
   end

   assign tx_pps        = pps_r;
   assign tx_throughput = thr_r;

endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: paces start requests for one XGMII TX frame generator.
// Per-second statistics are built only when TX_SCHED_STATS_EN is defined.
module tx_frame_sched
   import tx_sched_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 156_250_000,
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MIN_IFG = 12
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        tx_enable,
   input  logic [15:0] tx_frame_len,
   input  logic [31:0] tx_inter_frame_gap,
   output logic        frame_req,
   input  logic        frame_ack,
   output logic [15:0] frame_len_o,
   output logic [31:0] frame_seq,
   output logic        busy,
   output logic [31:0] tx_pps,
   output logic [31:0] tx_throughput
);

   tx_state_e   state_r;
   tx_state_e   state_s;
   logic [29:0] cnt_r;
   logic [29:0] cnt_s;
   logic [29:0] gap_cyc_r;
   logic [15:0] len_r;
   logic [31:0] ifg_r;
   logic [31:0] seq_r;
   logic        frame_req_r;
   logic        busy_r;
   logic        hs_s;
   logic        load_cfg_s;
   logic [13:0] frame_cyc_s;
   logic [29:0] gap_cyc_s;

   assign hs_s        = frame_req_r & frame_ack;
   assign load_cfg_s  = (state_s == ST_REQ) && (state_r != ST_REQ);
   assign frame_cyc_s = frame_cycles({1'b0, len_r});
   assign gap_cyc_s   = gap_cycles(ifg_r, 33'(MIN_IFG));

   // Next-state and cycle-counter decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (tx_enable) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (hs_s) begin
               if (frame_cyc_s == 14'd1) begin
                  state_s = ST_GAP;
                  cnt_s   = gap_cyc_s - 30'd1;
               end else begin
                  state_s = ST_SEND;
                  cnt_s   = 30'(frame_cyc_s) - 30'd2;
               end
            end else if (!tx_enable) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_SEND: begin
            if (cnt_r == 30'd0) begin
               state_s = ST_GAP;
               cnt_s   = gap_cyc_r - 30'd1;
            end else begin
               cnt_s = cnt_r - 30'd1;
            end
         end
         ST_GAP: begin
            if (cnt_r == 30'd0) begin
               state_s = tx_enable ? ST_REQ : ST_IDLE;
            end else begin
               cnt_s = cnt_r - 30'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 30'd0;
         end
      endcase
   end

   // State, counter and registered request/busy outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 30'd0;
         frame_req_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         frame_req_r <= (state_s == ST_REQ);
         busy_r      <= (state_s != ST_IDLE);
      end
   end

   // Configuration is captured on entry to REQ so the offered frame stays stable.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         len_r <= 16'd0;
         ifg_r <= 32'd0;
      end else if (load_cfg_s) begin
         len_r <= clamp_len(tx_frame_len, 16'(MIN_LEN));
         ifg_r <= tx_inter_frame_gap;
      end
   end

   // Gap length and sequence number advance on the handshake.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         gap_cyc_r <= 30'd0;
         seq_r     <= 32'd0;
      end else if (hs_s) begin
         gap_cyc_r <= gap_cyc_s;
         seq_r     <= seq_r + 32'd1;
      end
   end

   assign frame_req   = frame_req_r;
   assign busy        = busy_r;
   assign frame_len_o = len_r;
   assign frame_seq   = seq_r;

`ifdef TX_SCHED_STATS_EN
   tx_rate_stats #(
      .CLK_HZ (CLK_HZ)
   ) u_stats (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .frame_acc     (hs_s),
      .frame_bits    ({len_r, 3'b000}),
      .tx_pps        (tx_pps),
      .tx_throughput (tx_throughput)
   );
`else
   assign tx_pps        = 32'd0;
   assign tx_throughput = 32'd0;
`endif

endmodule

// File: tb/tb_tx_frame_sched.sv
// Self-checking bench for tx_frame_sched: vector table, corner sequences and
// random acks, all compared against a cycle-budget reference model.
module tb_tx_frame_sched;

   localparam int unsigned CLK_HZ  = 120;
   localparam int unsigned MIN_LEN = 64;
   localparam int unsigned MIN_IFG = 12;
   localparam longint      SAT32   = 64'h0000_0000_FFFF_FFFF;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        tx_enable = 1'b0;
   logic [15:0] tx_frame_len = 16'd68;
   logic [31:0] tx_inter_frame_gap = 32'd12;
   logic        frame_ack = 1'b0;
   logic        frame_req;
   logic [15:0] frame_len_o;
   logic [31:0] frame_seq;
   logic        busy;
   logic [31:0] tx_pps;
   logic [31:0] tx_throughput;

   tx_frame_sched #(.CLK_HZ(CLK_HZ), .MIN_LEN(MIN_LEN), .MIN_IFG(MIN_IFG)) dut (
      .sys_clk            (sys_clk),
      .sys_rst_n          (sys_rst_n),
      .tx_enable          (tx_enable),
      .tx_frame_len       (tx_frame_len),
      .tx_inter_frame_gap (tx_inter_frame_gap),
      .frame_req          (frame_req),
      .frame_ack          (frame_ack),
      .frame_len_o        (frame_len_o),
      .frame_seq          (frame_seq),
      .busy               (busy),
      .tx_pps             (tx_pps),
      .tx_throughput      (tx_throughput)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [15:0] len;
      logic [31:0] ifg;
      int          ack_wait;
      int          exp_period;
      logic [15:0] exp_len;
   } vec_t;

   vec_t        vecs[6];
   int          checks = 0;
   int          errors = 0;
   // model: 0 idle, 1 requesting, 2 frame+gap in progress
   int          m_mode;
   longint      m_rem;
   longint      m_seq;
   int          m_win;
   longint      m_acc_f, m_acc_b, m_pps, m_thr;
   int          cyc = 0;
   int          req_age = 0;
   int          req_seen = 0;
   int          hs_times[$];
   logic [15:0] hs_lens[$];
   logic [31:0] hs_seqs[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint clamp_len(input longint l);
      return (l < MIN_LEN) ? longint'(MIN_LEN) : l;
   endfunction

   function automatic longint period_of(input longint l, input longint ifg);
      longint fc, g, gc;
      fc = (clamp_len(l) + 8 + 7) / 8;
      g  = (ifg < MIN_IFG) ? longint'(MIN_IFG) : ifg;
      gc = (g + 7) / 8;
      if (gc < 1) gc = 1;
      if (gc > (longint'(1) << 29)) gc = longint'(1) << 29;
      return fc + gc;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_rem = 0; m_seq = 0; m_win = 0;
      m_acc_f = 0; m_acc_b = 0; m_pps = 0; m_thr = 0;
   endtask

   task automatic check_outputs();
      check("frame_req", frame_req, (m_mode == 1) ? 1 : 0);
      check("busy", busy, (m_mode != 0) ? 1 : 0);
      if (m_mode == 1) begin
         check("frame_len_o", frame_len_o, clamp_len(tx_frame_len));
         check("frame_seq", frame_seq, m_seq);
      end
`ifdef TX_SCHED_STATS_EN
      check("tx_pps", tx_pps, m_pps);
      check("tx_throughput", tx_throughput, m_thr);
`else
      check("tx_pps", tx_pps, 0);
      check("tx_throughput", tx_throughput, 0);
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req"}, frame_req, 0);
      check({tag, "_len"}, frame_len_o, 0);
      check({tag, "_seq"}, frame_seq, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pps"}, tx_pps, 0);
      check({tag, "_thr"}, tx_throughput, 0);
   endtask

   // One clock cycle: drive, check, clock edge, advance the model.
   task automatic step(input bit en, input bit ack);
      bit     hs;
      longint bits;
      tx_enable = en;
      frame_ack = ack;
      check_outputs();
      if (frame_req) req_seen++;
      if (frame_req && ack) begin
         hs_times.push_back(cyc);
         hs_lens.push_back(frame_len_o);
         hs_seqs.push_back(frame_seq);
      end
      @(posedge sys_clk);
      hs   = (m_mode == 1) && ack;
      bits = clamp_len(tx_frame_len) * 8;
      if (m_win == int'(CLK_HZ) - 1) begin
         m_pps = m_acc_f; m_thr = m_acc_b;
         m_acc_f = hs ? 1 : 0;
         m_acc_b = hs ? bits : 0;
         m_win = 0;
      end else begin
         m_win++;
         if (hs) begin
            m_acc_f = (m_acc_f + 1 > SAT32) ? SAT32 : m_acc_f + 1;
            m_acc_b = (m_acc_b + bits > SAT32) ? SAT32 : m_acc_b + bits;
         end
      end
      case (m_mode)
         0: if (en) m_mode = 1;
         1: begin
            if (hs) begin
               m_seq  = (m_seq + 1) % (longint'(1) << 32);
               m_rem  = period_of(tx_frame_len, tx_inter_frame_gap) - 1;
               m_mode = 2;
            end else if (!en) begin
               m_mode = 0;
            end
         end
         default: begin
            m_rem--;
            if (m_rem == 0) m_mode = en ? 1 : 0;
         end
      endcase
      cyc++;
      @(negedge sys_clk);
   endtask

   task automatic run(input int n, input bit en, input int ack_wait, input bit rnd_ack);
      bit ack, was_req;
      for (int i = 0; i < n; i++) begin
         was_req = (m_mode == 1);
         if (rnd_ack) ack = was_req && ($urandom_range(0, 3) == 0);
         else ack = was_req && (req_age >= ack_wait);
         step(en, ack);
         if (m_mode == 1 && was_req && !ack) req_age++;
         else req_age = 0;
      end
   endtask

   task automatic run_until_hs(input int count, input int ack_wait, input int budget);
      for (int k = 0; k < budget && hs_times.size() < count; k++) run(1, 1'b1, ack_wait, 1'b0);
      check("hs_within_budget", hs_times.size(), count);
   endtask

   task automatic drain();
      for (int k = 0; k < 600 && m_mode != 0; k++) run(1, 1'b0, 0, 1'b0);
      check("drained_busy", busy, 0);
   endtask

   task automatic clear_log();
      hs_times.delete(); hs_lens.delete(); hs_seqs.delete(); req_seen = 0;
   endtask

   initial begin
      vecs[0] = '{16'd68,   32'd12, 0, 12,  16'd68};
      vecs[1] = '{16'd40,   32'd0,  0, 11,  16'd64};
      vecs[2] = '{16'd68,   32'd12, 5, 17,  16'd68};
      vecs[3] = '{16'd100,  32'd20, 2, 19,  16'd100};
      vecs[4] = '{16'd65,   32'd13, 1, 13,  16'd65};
      vecs[5] = '{16'd1500, 32'd96, 0, 201, 16'd1500};

      model_reset();
      repeat (3) @(negedge sys_clk);
      check_zero("reset");
      sys_rst_n = 1'b1;

      // Statistics over the first window after reset, 68/12 with ack immediate.
      clear_log();
      run(125, 1'b1, 0, 1'b0);
`ifdef TX_SCHED_STATS_EN
      check("first_window_pps", tx_pps, 10);
      check("first_window_thr", tx_throughput, 5440);
`else
      check("first_window_pps", tx_pps, 0);
      check("first_window_thr", tx_throughput, 0);
`endif
      if (hs_seqs.size() >= 3) begin
         check("seq0", hs_seqs[0], 0);
         check("seq1", hs_seqs[1], 1);
         check("seq2", hs_seqs[2], 2);
      end
      drain();

      // Table of length/gap/ack-delay cases with expected steady period.
      for (int i = 0; i < 6; i++) begin
         tx_frame_len = vecs[i].len;
         tx_inter_frame_gap = vecs[i].ifg;
         clear_log();
         run_until_hs(4, vecs[i].ack_wait, 1200);
         if (hs_times.size() >= 3) check($sformatf("period_v%0d", i), hs_times[2] - hs_times[1], vecs[i].exp_period);
         if (hs_lens.size() >= 1) check($sformatf("len_v%0d", i), hs_lens[0], vecs[i].exp_len);
         drain();
      end

      // Enable dropped mid-SEND: frame and gap finish, no new request.
      tx_frame_len = 16'd68; tx_inter_frame_gap = 32'd12;
      clear_log();
      run_until_hs(1, 0, 50);
      run(3, 1'b1, 0, 1'b0);
      check("busy_in_send", busy, 1);
      clear_log();
      run(20, 1'b0, 0, 1'b0);
      check("no_req_after_drop", req_seen, 0);
      check("idle_after_drop", busy, 0);

      // Enable dropped while REQ waits for an ack.
      run(3, 1'b1, 99, 1'b0);
      check("req_waiting", frame_req, 1);
      run(1, 1'b0, 99, 1'b0);
      check("req_dropped", frame_req, 0);
      check("req_drop_idle", busy, 0);

      // Random lengths, gaps and ack timing.
      for (int r = 0; r < 6; r++) begin
         tx_frame_len = 16'($urandom_range(20, 400));
         tx_inter_frame_gap = $urandom_range(0, 50);
         run($urandom_range(40, 120), 1'b1, 0, 1'b1);
         drain();
      end

      // Reset asserted in GAP clears everything at once; restart from seq 0.
      tx_frame_len = 16'd68; tx_inter_frame_gap = 32'd12;
      clear_log();
      run_until_hs(1, 0, 50);
      run(9, 1'b1, 0, 1'b0);
      check("in_gap_busy", busy, 1);
      #2 sys_rst_n = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      clear_log();
      run_until_hs(2, 0, 50);
      if (hs_seqs.size() >= 2) begin
         check("restart_seq0", hs_seqs[0], 0);
         check("restart_seq1", hs_seqs[1], 1);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
